// File: rtl/lsu_mem_stage.sv
// Memory-stage load/store unit: aligns stores, extends loads, stalls on access.
// Define LSU_MISALIGN_SPLIT_EN to split misaligned accesses into two words.
module lsu_mem_stage (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        insn_vldM,
    input  logic        rd_wrenM,
    input  logic [1:0]  wb_selM,
    input  logic        mem_wrenM,
    input  logic [31:0] alu_dataM,
    input  logic [31:0] st_dataM,
    input  logic [2:0]  load_selM,
    input  logic [1:0]  store_selM,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] ld_dataM,
    output logic        stallM,
    output logic        misalignM
);

    typedef enum logic [1:0] {IDLE, ACC0, ACC1, DONE} state_t;

    state_t      state_q;
    state_t      state_d;

    logic        is_load;
    logic        memop;
    logic        ack_v;
    logic [1:0]  off;
    logic [1:0]  sz;
    logic        misal;
    logic [3:0]  mask;
    logic [31:0] st_mask;
    logic [3:0]  be_lo;
    logic [31:0] wd_lo;

    logic [1:0]  off_q;
    logic [1:0]  sz_q;
    logic        sign_q;

    assign is_load = rd_wrenM & (wb_selM == 2'b01);
    assign memop   = insn_vldM & (mem_wrenM | is_load);
    assign ack_v   = dmem_ack & dmem_req;
    assign off     = alu_dataM[1:0];

    // sz: 0 byte, 1 half, 2 word
    always_comb begin
        sz = 2'd2;
        if (mem_wrenM) begin
            case (store_selM)
                2'b00:   sz = 2'd0;
                2'b01:   sz = 2'd1;
                default: sz = 2'd2;
            endcase
        end else begin
            case (load_selM)
                3'b000, 3'b100: sz = 2'd0;
                3'b001, 3'b101: sz = 2'd1;
                default:        sz = 2'd2;
            endcase
        end
    end

    always_comb begin
        mask    = 4'b1111;
        st_mask = 32'hFFFF_FFFF;
        case (sz)
            2'd0: begin
                mask    = 4'b0001;
                st_mask = 32'h0000_00FF;
            end
            2'd1: begin
                mask    = 4'b0011;
                st_mask = 32'h0000_FFFF;
            end
            default: ;
        endcase
    end

    assign misal = ((sz == 2'd1) & off[0])
                 | ((sz == 2'd2) & (off != 2'd0));

`ifdef LSU_MISALIGN_SPLIT_EN
    logic [2:0]  nbytes;
    logic        split;
    logic [7:0]  be64;
    logic [63:0] wd64;
    logic        split_q;
    logic [3:0]  be_hi_q;
    logic [31:0] wd_hi_q;
    logic [31:0] w0_q;

    assign nbytes = (sz == 2'd0) ? 3'd1 : (sz == 2'd1) ? 3'd2 : 3'd4;
    assign split  = misal & (({1'b0, off} + nbytes) > 3'd4);
    assign be64   = {4'b0000, mask} << off;
    assign wd64   = {32'h0, st_dataM & st_mask} << {off, 3'b000};
    assign be_lo  = be64[3:0];
    assign wd_lo  = wd64[31:0];
`else
    assign be_lo  = mask << off;
    assign wd_lo  = (st_dataM & st_mask) << {off, 3'b000};
`endif

    function automatic logic [31:0] extend(
        input logic [63:0] cat,
        input logic [1:0]  o,
        input logic [1:0]  s,
        input logic        sg
    );
        logic [31:0] v;
        v = 32'(cat >> {o, 3'b000});
        case (s)
            2'd0:    extend = {{24{sg & v[7]}}, v[7:0]};
            2'd1:    extend = {{16{sg & v[15]}}, v[15:0]};
            default: extend = v;
        endcase
    endfunction

    always_ff @(posedge i_clk) begin
        if (i_rst) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        stallM  = 1'b0;
        case (state_q)
            IDLE: begin
                if (memop) begin
                    stallM  = 1'b1;
`ifdef LSU_MISALIGN_SPLIT_EN
                    state_d = ACC0;
`else
                    state_d = misal ? DONE : ACC0;
`endif
                end
            end
            ACC0: begin
                stallM = 1'b1;
                if (ack_v) begin
`ifdef LSU_MISALIGN_SPLIT_EN
                    state_d = split_q ? ACC1 : DONE;
`else
                    state_d = DONE;
`endif
                end
            end
`ifdef LSU_MISALIGN_SPLIT_EN
            ACC1: begin
                stallM = 1'b1;
                if (ack_v) state_d = DONE;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_be    <= '0;
            dmem_wdata <= '0;
            ld_dataM   <= '0;
            misalignM  <= 1'b0;
            off_q      <= '0;
            sz_q       <= '0;
            sign_q     <= 1'b0;
`ifdef LSU_MISALIGN_SPLIT_EN
            split_q    <= 1'b0;
            be_hi_q    <= '0;
            wd_hi_q    <= '0;
            w0_q       <= '0;
`endif
        end else begin
            misalignM <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (memop) begin
                        off_q  <= off;
                        sz_q   <= sz;
                        sign_q <= ~load_selM[2];
`ifdef LSU_MISALIGN_SPLIT_EN
                        split_q <= split;
                        be_hi_q <= be64[7:4];
                        wd_hi_q <= wd64[63:32];
                        dmem_req   <= 1'b1;
                        dmem_we    <= mem_wrenM;
                        dmem_addr  <= {alu_dataM[31:2], 2'b00};
                        dmem_be    <= be_lo;
                        dmem_wdata <= wd_lo;
`else
                        if (misal) begin
                            ld_dataM  <= '0;
                            misalignM <= 1'b1;
                        end else begin
                            dmem_req   <= 1'b1;
                            dmem_we    <= mem_wrenM;
                            dmem_addr  <= {alu_dataM[31:2], 2'b00};
                            dmem_be    <= be_lo;
                            dmem_wdata <= wd_lo;
                        end
`endif
                    end
                end
                ACC0: begin
                    if (ack_v) begin
`ifdef LSU_MISALIGN_SPLIT_EN
                        if (split_q) begin
                            w0_q       <= dmem_rdata;
                            dmem_addr  <= dmem_addr + 32'd4;
                            dmem_be    <= be_hi_q;
                            dmem_wdata <= wd_hi_q;
                        end else begin
                            dmem_req <= 1'b0;
                            ld_dataM <= extend({32'h0, dmem_rdata},
                                               off_q, sz_q, sign_q);
                        end
`else
                        dmem_req <= 1'b0;
                        ld_dataM <= extend({32'h0, dmem_rdata},
                                           off_q, sz_q, sign_q);
`endif
                    end
                end
`ifdef LSU_MISALIGN_SPLIT_EN
                ACC1: begin
                    if (ack_v) begin
                        dmem_req <= 1'b0;
                        ld_dataM <= extend({dmem_rdata, w0_q},
                                           off_q, sz_q, sign_q);
                    end
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Bench for lsu_mem_stage: byte-addressed reference model plus bus responder.
module tb_lsu_mem_stage;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        insn_vldM;
    logic        rd_wrenM;
    logic [1:0]  wb_selM;
    logic        mem_wrenM;
    logic [31:0] alu_dataM;
    logic [31:0] st_dataM;
    logic [2:0]  load_selM;
    logic [1:0]  store_selM;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic [31:0] ld_dataM;
    logic        stallM;
    logic        misalignM;

    lsu_mem_stage dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .insn_vldM  (insn_vldM),
        .rd_wrenM   (rd_wrenM),
        .wb_selM    (wb_selM),
        .mem_wrenM  (mem_wrenM),
        .alu_dataM  (alu_dataM),
        .st_dataM   (st_dataM),
        .load_selM  (load_selM),
        .store_selM (store_selM),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_be    (dmem_be),
        .dmem_wdata (dmem_wdata),
        .dmem_ack   (dmem_ack),
        .dmem_rdata (dmem_rdata),
        .ld_dataM   (ld_dataM),
        .stallM     (stallM),
        .misalignM  (misalignM)
    );

    always #5 i_clk = ~i_clk;

    int ncmp = 0;
    int nerr = 0;

    // responder memory (word) and reference memory (byte)
    logic [31:0] wmem [logic [29:0]];
    logic [7:0]  bmem [logic [31:0]];
    logic [31:0] last_ld;
    bit          last_is_ld;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] mbyte(input logic [31:0] a);
        return bmem.exists(a) ? bmem[a] : 8'h00;
    endfunction

    function automatic logic [31:0] rword(input logic [29:0] i);
        return wmem.exists(i) ? wmem[i] : 32'h0;
    endfunction

    task automatic set_word(input logic [31:0] a, input logic [31:0] v);
        wmem[a[31:2]] = v;
        for (int j = 0; j < 4; j++)
            bmem[{a[31:2], 2'b00} + 32'(j)] = v[8*j +: 8];
    endtask

    task automatic do_op(input bit st, input logic [2:0] lsel,
                         input logic [1:0] ssel, input logic [31:0] addr,
                         input logic [31:0] sd, input int w0, input int w1,
                         input bit spur);
        int          nb, off, nreq, k, wl, stalls, exp_stalls;
        bit          sgn, misal, split, skip, done;
        logic [31:0] exp_ld, obs_st, exp_st, ra, ewd, lm, w;
        logic [3:0]  ebe;
        if (st) nb = (ssel == 2'b00) ? 1 : (ssel == 2'b01) ? 2 : 4;
        else begin
            case (lsel)
                3'b000, 3'b100: nb = 1;
                3'b001, 3'b101: nb = 2;
                default:        nb = 4;
            endcase
        end
        sgn   = !st && (lsel == 3'b000 || lsel == 3'b001);
        off   = int'(addr[1:0]);
        misal = (nb == 2 && off % 2 == 1) || (nb == 4 && off != 0);
        split = misal && (off + nb > 4);
`ifdef LSU_MISALIGN_SPLIT_EN
        skip = 1'b0;
`else
        skip = misal;
`endif
        nreq = skip ? 0 : (split ? 2 : 1);
        exp_stalls = skip ? 1 : (split ? 3 + w0 + w1 : 2 + w0);
        exp_ld = 32'h0;
        if (!skip) begin
            for (int i = 0; i < nb; i++)
                exp_ld[8*i +: 8] = mbyte(addr + 32'(i));
            if (sgn && exp_ld[8*nb-1])
                exp_ld = exp_ld | (32'hFFFF_FFFF << (8*nb));
        end

        @(negedge i_clk);
        insn_vldM  = 1'b1;
        mem_wrenM  = st;
        rd_wrenM   = !st;
        wb_selM    = st ? 2'b00 : 2'b01;
        alu_dataM  = addr;
        st_dataM   = sd;
        load_selM  = lsel;
        store_selM = ssel;
        k = 0; wl = w0; stalls = 0; done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            #1;
            if (c > 0 && !stallM) begin
                done = 1'b1;
                dmem_ack = 1'b0;
            end else begin
                if (stallM) stalls++;
                if (dmem_req) begin
                    if (k >= nreq) begin
                        chk("extra_req", 32'(dmem_req), 32'd0);
                    end else begin
                        ra  = {addr[31:2], 2'b00} + 32'(4 * k);
                        ebe = 4'b0;
                        ewd = 32'h0;
                        for (int j = 0; j < 4; j++) begin
                            if (ra + 32'(j) >= addr &&
                                ra + 32'(j) < addr + 32'(nb)) begin
                                ebe[j] = 1'b1;
                                ewd[8*j +: 8] =
                                    sd[8*(ra + 32'(j) - addr) +: 8];
                            end
                        end
                        lm = {{8{ebe[3]}}, {8{ebe[2]}},
                              {8{ebe[1]}}, {8{ebe[0]}}};
                        chk("req_addr", dmem_addr, ra);
                        chk("req_we", 32'(dmem_we), 32'(st));
                        chk("req_be", 32'(dmem_be), 32'(ebe));
                        chk("req_wdata", dmem_wdata & lm, ewd);
                    end
                    if (wl == 0) begin
                        dmem_ack   = 1'b1;
                        dmem_rdata = rword(dmem_addr[31:2]);
                        if (dmem_we) begin
                            w = rword(dmem_addr[31:2]);
                            for (int j = 0; j < 4; j++)
                                if (dmem_be[j])
                                    w[8*j +: 8] = dmem_wdata[8*j +: 8];
                            wmem[dmem_addr[31:2]] = w;
                        end
                        k++;
                        wl = w1;
                    end else begin
                        dmem_ack   = 1'b0;
                        dmem_rdata = $urandom;
                        wl--;
                    end
                end else begin
                    dmem_ack   = spur ? 1'($urandom % 2) : 1'b0;
                    dmem_rdata = $urandom;
                end
                @(negedge i_clk);
            end
        end
        chk("op_done", 32'(done), 32'd1);
        chk("done_req", 32'(dmem_req), 32'd0);
        chk("req_count", 32'(k), 32'(nreq));
        chk("stall_cycles", 32'(stalls), 32'(exp_stalls));
        chk("misalign", 32'(misalignM), 32'(skip));
        if (st) begin
            if (!skip)
                for (int i = 0; i < nb; i++)
                    bmem[addr + 32'(i)] = sd[8*i +: 8];
            exp_st = 32'h0;
            obs_st = 32'h0;
            for (int i = 0; i < nb; i++) begin
                exp_st[8*i +: 8] = mbyte(addr + 32'(i));
                w = rword(32'(addr + 32'(i)) >> 2);
                obs_st[8*i +: 8] = w[8*((addr[1:0] + i) % 4) +: 8];
            end
            chk("st_mem", obs_st, exp_st);
            last_is_ld = 1'b0;
        end else begin
            chk("ld_data", ld_dataM, exp_ld);
            last_ld    = exp_ld;
            last_is_ld = 1'b1;
        end
    endtask

    task automatic idle(input int n);
        logic [1:0] wbs [3];
        wbs = '{2'b00, 2'b10, 2'b11};
        for (int i = 0; i < n; i++) begin
            @(negedge i_clk);
            insn_vldM = 1'($urandom % 2);
            rd_wrenM  = 1'($urandom % 2);
            wb_selM   = wbs[$urandom % 3];
            mem_wrenM = 1'b0;
            alu_dataM = $urandom;
            dmem_ack  = 1'($urandom % 2);
            #1;
            chk("idle_stall", 32'(stallM), 32'd0);
            chk("idle_req", 32'(dmem_req), 32'd0);
            if (last_is_ld) chk("ld_hold", ld_dataM, last_ld);
        end
        dmem_ack = 1'b0;
    endtask

    initial begin
        i_rst = 1'b1;
        insn_vldM = 1'b0; rd_wrenM = 1'b0; wb_selM = 2'b00;
        mem_wrenM = 1'b0; alu_dataM = 32'h0; st_dataM = 32'h0;
        load_selM = 3'b000; store_selM = 2'b00;
        dmem_ack = 1'b0; dmem_rdata = 32'h0;
        last_ld = 32'h0; last_is_ld = 1'b1;

        repeat (2) @(negedge i_clk);
        #1;
        chk("rst_req", 32'(dmem_req), 32'd0);
        chk("rst_we", 32'(dmem_we), 32'd0);
        chk("rst_be", 32'(dmem_be), 32'd0);
        chk("rst_addr", dmem_addr, 32'h0);
        chk("rst_wdata", dmem_wdata, 32'h0);
        chk("rst_ld", ld_dataM, 32'h0);
        chk("rst_misalign", 32'(misalignM), 32'd0);
        chk("rst_stall", 32'(stallM), 32'd0);
        i_rst = 1'b0;
        idle(2);

        set_word(32'h1000, 32'hDEAD_BEEF);
        do_op(1'b0, 3'b010, 2'b00, 32'h1000, 32'h0, 0, 0, 1'b0);
        chk("lw_const", ld_dataM, 32'hDEAD_BEEF);

        set_word(32'h2000, 32'h8012_3456);
        do_op(1'b0, 3'b000, 2'b00, 32'h2003, 32'h0, 0, 0, 1'b0);
        chk("lb_const", ld_dataM, 32'hFFFF_FF80);
        do_op(1'b0, 3'b100, 2'b00, 32'h2003, 32'h0, 1, 0, 1'b1);
        chk("lbu_const", ld_dataM, 32'h0000_0080);

        do_op(1'b1, 3'b000, 2'b01, 32'h3002, 32'h0000_ABCD, 0, 0, 1'b0);
        idle(1);
        do_op(1'b1, 3'b000, 2'b10, 32'h3004, 32'h1234_5678, 3, 0, 1'b1);

        set_word(32'h1000, 32'h4433_2211);
        set_word(32'h1004, 32'h8877_6655);
        do_op(1'b0, 3'b010, 2'b00, 32'h1003, 32'h0, 1, 2, 1'b0);
`ifdef LSU_MISALIGN_SPLIT_EN
        chk("mis_lw_const", ld_dataM, 32'h7766_5544);
`else
        chk("mis_lw_const", ld_dataM, 32'h0);
`endif

        set_word(32'h5000, 32'hF1E2_D3C4);
        set_word(32'h5004, 32'hB5A6_9788);
        do_op(1'b0, 3'b001, 2'b00, 32'h5001, 32'h0, 0, 0, 1'b0);
        do_op(1'b0, 3'b101, 2'b00, 32'h5003, 32'h0, 2, 1, 1'b1);
        do_op(1'b1, 3'b000, 2'b00, 32'h5002, 32'hFFFF_FF5A, 0, 0, 1'b0);
        do_op(1'b1, 3'b000, 2'b11, 32'h5006, 32'hCAFE_1234, 1, 1, 1'b0);

        // reset while the first request waits for its ack
        @(negedge i_clk);
        insn_vldM = 1'b1; rd_wrenM = 1'b1; wb_selM = 2'b01;
        mem_wrenM = 1'b0; load_selM = 3'b010; alu_dataM = 32'h1000;
        dmem_ack = 1'b0;
        @(negedge i_clk);
        #1;
        chk("midrst_req_before", 32'(dmem_req), 32'd1);
        i_rst = 1'b1; insn_vldM = 1'b0;
        dmem_ack = 1'b1; dmem_rdata = 32'hCAFE_F00D;
        @(negedge i_clk);
        #1;
        chk("midrst_req", 32'(dmem_req), 32'd0);
        chk("midrst_we", 32'(dmem_we), 32'd0);
        chk("midrst_be", 32'(dmem_be), 32'd0);
        chk("midrst_addr", dmem_addr, 32'h0);
        chk("midrst_wdata", dmem_wdata, 32'h0);
        chk("midrst_ld", ld_dataM, 32'h0);
        chk("midrst_stall", 32'(stallM), 32'd0);
        i_rst = 1'b0;
        @(negedge i_clk);
        #1;
        chk("late_ack_req", 32'(dmem_req), 32'd0);
        chk("late_ack_stall", 32'(stallM), 32'd0);
        chk("late_ack_ld", ld_dataM, 32'h0);
        dmem_ack = 1'b0;
        last_ld = 32'h0; last_is_ld = 1'b1;

        for (int a = 0; a < 264; a += 4)
            set_word(32'h4000 + 32'(a), $urandom);
        for (int n = 0; n < 80; n++) begin
            do_op(1'($urandom % 2), 3'($urandom % 8), 2'($urandom % 4),
                  32'h4000 + 32'($urandom_range(0, 251)), $urandom,
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  1'b1);
            idle(int'($urandom_range(0, 2)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 ncmp, nerr);
        $finish;
    end

endmodule

// File: doc/lsu_mem_stage.md
# lsu_mem_stage

Memory-stage load/store unit; consumes the EX/MEM pipeline register outputs and drives the data-memory request/acknowledge bus. Aligns store data and byte enables, extracts and sign/zero-extends load data, and stalls the pipeline while an access is in flight. Optionally splits misaligned accesses into two word transactions. Sits between the EX/MEM register and the MEM/WB register.

## Interface
- No parameters; data and address width fixed at 32.
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  synchronous reset, active-high.
- insn_vldM  in  1  valid instruction in M.
- rd_wrenM  in  1  load marker: a load is `rd_wrenM & wb_selM==2'b01`.
- wb_selM  in  2  writeback select; `2'b01` is memory data.
- mem_wrenM  in  1  store.
- alu_dataM  in  32  effective byte address.
- st_dataM  in  32  store data, right-justified.
- load_selM  in  3  `000` LB, `001` LH, `010` LW, `100` LBU, `101` LHU; other codes are treated as LW.
- store_selM  in  2  `00` SB, `01` SH, `10` SW; `11` is treated as SW.
- dmem_req  out  1  request valid; registered.
- dmem_we  out  1  write.
- dmem_addr  out  32  word address; bits [1:0] always 0.
- dmem_be  out  4  byte enables; write only.
- dmem_wdata  out  32  lane-aligned write data.
- dmem_ack  in  1  access complete; may be high in the same cycle `dmem_req` rises. `dmem_rdata` is valid with it.
- dmem_rdata  in  32  read word.
- ld_dataM  out  32  extended load result; registered; valid in DONE.
- stallM  out  1  hold F/D/E/M registers; combinational from state.
- misalignM  out  1  misaligned-access flag; registered; valid in DONE.

## Operation
- A memory op is `insn_vldM & (mem_wrenM | load)`.
- Access size and offset:
  - Size is 1, 2 or 4 bytes from the select field.
  - `off = alu_dataM[1:0]`.
  - Misaligned means: halfword with `off[0]=1`, or word with `off!=0`.
  - `split = misaligned & (off + size > 4)`.
  - A halfword with `off==1` is misaligned but not split.
- States: IDLE, ACC0, ACC1, DONE.
- IDLE:
  - No memory op: stay in IDLE; `stallM=0`.
  - Memory op: `stallM=1`. Capture address, size, offset, sign flag, store flag, and 64-bit shifted store data and enables. Go to ACC0, which asserts `dmem_req` from the next cycle.
- ACC0:
  - `dmem_addr = {addr[31:2],2'b00}`. `dmem_be` and `dmem_wdata` are the lower 4 lanes of `mask<<off` and `st_data<<(8*off)`.
  - On `dmem_ack`: capture `dmem_rdata` as w0. Go to ACC1 if split, else DONE.
- ACC1:
  - `dmem_addr = word addr + 4`. Upper 4 lanes of enables and data.
  - `dmem_req` stays high continuously from ACC0.
  - On `dmem_ack`: capture w1; go to DONE.
- DONE:
  - `dmem_req=0`; `stallM=0`.
  - `ld_dataM = extend(({w1,w0} >> 8*off)[size-1:0])`. Stores and non-split accesses use `w1=0`.
  - Unconditionally go to IDLE. The EX/MEM register advances at the end of DONE.
- Request rules:
  - `dmem_addr`, `dmem_we`, `dmem_be` and `dmem_wdata` are stable while `dmem_req=1` and `dmem_ack=0`.
  - `dmem_ack` is ignored when `dmem_req=0`.
- `stallM = (IDLE & memop) | ACC0 | ACC1`.
- `ld_dataM` holds its value outside DONE.

## Timing
- Reset values: state IDLE; `dmem_req`, `dmem_we`, `dmem_be`, `dmem_addr`, `dmem_wdata`, `ld_dataM` and `misalignM` are all 0.
- Reset mid-access: return to IDLE next edge with `dmem_req=0`. A late `dmem_ack` is dropped.
- Latency:
  - Non-split access with zero-wait ack: 3 cycles (IDLE, ACC0, DONE), i.e. 2 stall cycles.
  - Each wait cycle adds 1. A split access adds 1 + its wait cycles.
- Non-memory instructions incur no stall.
- A memory op arriving in the cycle after DONE starts immediately from IDLE.

## Configuration
- `LSU_MISALIGN_SPLIT_EN` defined:
  - Split accesses use ACC1.
  - An unsplit misaligned halfword at `off==1` completes in one access.
  - `misalignM=0` always.
- Not defined:
  - Any misaligned access goes IDLE -> DONE with no `dmem_req`, so a store is suppressed.
  - `ld_dataM=0`; `misalignM=1` in DONE.
  - ACC1 logic is absent.

## Test plan
- **LW, aligned:** LW at `0x1000`, ack same cycle, rdata `0xDEADBEEF` -> one request to `0x1000`; `ld_dataM=0xDEADBEEF` in cycle 3; `stallM` high for 2 cycles.
- **LB with sign extension:** LB at `0x2003`, rdata `0x80123456` -> `ld_dataM=0xFFFFFF80`. LBU at the same address -> `0x00000080`.
- **SH:** SH at `0x3002`, `st_data=0x0000ABCD` -> `dmem_we=1`, `be=4'b1100`, `wdata=0xABCD0000`, `addr=0x3000`.
- **Wait states:** `dmem_ack` delayed 3 cycles on an SW -> request and all request fields stable for 4 cycles; `stallM` deasserts only in DONE.
- **Misaligned LW:** LW at `0x1003`, words `0x44332211` at `0x1000` and `0x88776655` at `0x1004`.
  - With `LSU_MISALIGN_SPLIT_EN`: requests to `0x1000` then `0x1004`; `ld_dataM=0x77665544`.
  - Without it: no request; `misalignM=1`; `ld_dataM=0`.
- **Reset mid-access:** `i_rst` asserted in ACC0 with ack pending -> next cycle IDLE, `dmem_req=0`, all outputs 0.
